// File: rtl/rap_add_sched_pkg.sv
// Shared widths and index helpers for the round-robin approximate-adder scheduler.
// Optional exact-carry mode is enabled by defining RAP_EXACT_MODE_EN.
package rap_add_sched_pkg;
  localparam int RAP_W   = 16;
  localparam int RAP_WIN = 4;

  function automatic int rap_tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Adds an offset to a requester index and wraps it into 0..n-1.
  function automatic int rap_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction
endpackage

// File: rtl/rap_add_sched_if.sv
// Requester-side operand and response bundle of rap_add_sched.
// req_exact exists only when RAP_EXACT_MODE_EN is defined.
interface rap_add_sched_if
  import rap_add_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = RAP_W
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*W-1:0]     req_a;
  logic [NREQ*W-1:0]     req_b;
`ifdef RAP_EXACT_MODE_EN
  logic [NREQ-1:0]       req_exact;
`endif
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ*(W+1)-1:0] rsp_sum;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
`ifdef RAP_EXACT_MODE_EN
    output req_exact,
`endif
    input  req_ready, rsp_valid, rsp_sum, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
`ifdef RAP_EXACT_MODE_EN
    input  req_exact,
`endif
    output req_ready, rsp_valid, rsp_sum, busy
  );
endinterface

// File: rtl/rap_add_sched_core.sv
// Combinational 16-bit adder whose carries only look back RAP_WIN+1 bit positions.
// With RAP_EXACT_MODE_EN defined, the exact input selects a full ripple carry instead.
module rap_add_core
  import rap_add_sched_pkg::*;
(
  input  logic [RAP_W-1:0] a,
  input  logic [RAP_W-1:0] b,
`ifdef RAP_EXACT_MODE_EN
  input  logic             exact,
`endif
  output logic [RAP_W:0]   sum
);
  logic [RAP_W-1:0] p;
  logic [RAP_W-1:0] g;
  logic [RAP_W-1:0] carry_v;

  always_comb begin
    logic term;
`ifdef RAP_EXACT_MODE_EN
    logic rc;
    rc = 1'b0;
`endif
    term    = 1'b0;
    p       = a ^ b;
    g       = a & b;
    carry_v = '0;
    sum     = '0;
    // A carry into bit i+1 is only seen if generated within the last RAP_WIN+1 positions.
    for (int i = 0; i < RAP_W; i++) begin
      for (int j = 0; j <= ((i < RAP_WIN) ? i : RAP_WIN); j++) begin
        term = g[i-j];
        for (int k = i - j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        carry_v[i] = carry_v[i] | term;
      end
    end
`ifdef RAP_EXACT_MODE_EN
    if (exact) begin
      for (int i = 0; i < RAP_W; i++) begin
        rc         = g[i] | (p[i] & rc);
        carry_v[i] = rc;
      end
    end
`endif
    sum[0] = p[0];
    for (int i = 1; i < RAP_W; i++) begin
      sum[i] = p[i] ^ carry_v[i-1];
    end
    sum[RAP_W] = carry_v[RAP_W-1];
  end
endmodule

// File: rtl/rap_add_sched.sv
// Round-robin scheduler sharing one rap_add_core among NREQ requesters, one-entry response slots.
// Defining RAP_EXACT_MODE_EN adds a per-request exact-carry select carried with the operands.
module rap_add_sched
  import rap_add_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = RAP_W
) (
  input  logic           clk,
  input  logic           rst_n,
  rap_add_sched_if.slave bus
);
  localparam int TAG_W = rap_tag_w(NREQ);

  logic                  iss_vld_q, iss_vld_d;
  logic [TAG_W-1:0]      iss_tag_q, iss_tag_d;
  logic [W-1:0]          iss_a_q, iss_a_d;
  logic [W-1:0]          iss_b_q, iss_b_d;
`ifdef RAP_EXACT_MODE_EN
  logic                  iss_exact_q, iss_exact_d;
`endif
  logic [TAG_W-1:0]      rr_q, rr_d;
  logic [NREQ-1:0]       rsp_vld_q, rsp_vld_d;
  logic [NREQ*(W+1)-1:0] rsp_sum_q, rsp_sum_d;

  logic [NREQ-1:0]       elig;
  logic [NREQ-1:0]       elig_rot;
  logic [NREQ-1:0]       gnt;
  logic                  gnt_vld;
  logic [TAG_W-1:0]      gnt_idx;
  logic [W:0]            core_sum;

  rap_add_core u_core (
    .a     (iss_a_q),
    .b     (iss_b_q),
`ifdef RAP_EXACT_MODE_EN
    .exact (iss_exact_q),
`endif
    .sum   (core_sum)
  );

  // Rotating the eligible mask by the pointer turns round-robin into a lowest-set-bit search.
  always_comb begin
    elig    = '0;
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus.req_valid[i]
              & ~(iss_vld_q & (iss_tag_q == TAG_W'(i)))
              & (~rsp_vld_q[i] | bus.rsp_ready[i]);
    end
    elig_rot = NREQ'({elig, elig} >> rr_q);
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = TAG_W'(rap_wrap(int'(rr_q), k, NREQ));
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = gnt_vld & (gnt_idx == TAG_W'(i));
    end
  end

  always_comb begin
    iss_vld_d = gnt_vld;
    iss_tag_d = iss_tag_q;
    iss_a_d   = iss_a_q;
    iss_b_d   = iss_b_q;
`ifdef RAP_EXACT_MODE_EN
    iss_exact_d = iss_exact_q;
`endif
    rr_d      = rr_q;
    if (gnt_vld) begin
      iss_tag_d = gnt_idx;
      rr_d      = (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
      iss_a_d   = '0;
      iss_b_d   = '0;
`ifdef RAP_EXACT_MODE_EN
      iss_exact_d = 1'b0;
`endif
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          iss_a_d = bus.req_a[i*W +: W];
          iss_b_d = bus.req_b[i*W +: W];
`ifdef RAP_EXACT_MODE_EN
          iss_exact_d = bus.req_exact[i];
`endif
        end
      end
    end
    // A result landing in a slot overrides a drain of that slot on the same edge.
    rsp_vld_d = rsp_vld_q & ~bus.rsp_ready;
    rsp_sum_d = rsp_sum_q;
    if (iss_vld_q) begin
      for (int i = 0; i < NREQ; i++) begin
        if (iss_tag_q == TAG_W'(i)) begin
          rsp_vld_d[i]                 = 1'b1;
          rsp_sum_d[i*(W+1) +: (W+1)] = core_sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q   <= 1'b0;
      iss_tag_q   <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
`ifdef RAP_EXACT_MODE_EN
      iss_exact_q <= 1'b0;
`endif
      rr_q        <= '0;
      rsp_vld_q   <= '0;
      rsp_sum_q   <= '0;
    end else begin
      iss_vld_q   <= iss_vld_d;
      iss_tag_q   <= iss_tag_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
`ifdef RAP_EXACT_MODE_EN
      iss_exact_q <= iss_exact_d;
`endif
      rr_q        <= rr_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.busy      = iss_vld_q | (|rsp_vld_q);
endmodule

// File: tb/tb_rap_add_sched.sv
// Directed self-checking bench for rap_add_sched (NREQ=4); exact-mode vectors run when
// RAP_EXACT_MODE_EN is defined.
module tb_rap_add_sched;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rap_add_sched_if #(.NREQ(N), .W(16)) bus_if ();

  rap_add_sched #(.NREQ(N), .W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [16:0] slot(input int i);
    return bus_if.rsp_sum[i*17 +: 17];
  endfunction

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    bus_if.req_a[i*16 +: 16] = a;
    bus_if.req_b[i*16 +: 16] = b;
  endtask

  task automatic idle_inputs();
    bus_if.req_valid = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    bus_if.rsp_ready = '1;
`ifdef RAP_EXACT_MODE_EN
    bus_if.req_exact = '0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Issues one op on requester i; returns at the negedge after its result has landed.
  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b);
    int n;
    @(posedge clk);
    #1;
    set_req(i, a, b);
    bus_if.req_valid[i] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus_if.req_ready[i] && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) begin
      checks++;
      errors++;
      $display("[TB] FAIL op_grant_req%0d: req_ready=%b required grant", i, bus_if.req_ready);
    end
    @(posedge clk);
    #1;
    bus_if.req_valid[i] = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus_if.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", bus_if.req_ready); end
    checks++; if (bus_if.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", bus_if.rsp_valid); end
    checks++; if (bus_if.rsp_sum !== 68'h0) begin errors++; $display("[TB] FAIL reset_rsp_sum: got %h expected 0", bus_if.rsp_sum); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus_if.busy); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    set_req(0, 16'h000F, 16'h0001);
    bus_if.req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (bus_if.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL basic_grant: got %b expected 0001", bus_if.req_ready); end
    @(posedge clk);
    #1;
    bus_if.req_valid = '0;
    @(negedge clk);
    checks++; if (bus_if.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL basic_early_valid: got %b expected 0000", bus_if.rsp_valid); end
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_inflight: got %b expected 1", bus_if.busy); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus_if.rsp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL basic_rsp_valid: got %b expected 0001", bus_if.rsp_valid); end
    checks++; if (slot(0) !== 17'h00010) begin errors++; $display("[TB] FAIL basic_sum: got %h expected 00010", slot(0)); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus_if.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL basic_drain: got %b expected 0000", bus_if.rsp_valid); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_idle: got %b expected 0", bus_if.busy); end
  endtask

  task automatic test_long_carry();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic [16:0] ve [6];
    int          vr [6];
    int          nv;
    va = '{16'h00FF, 16'hFFFF, 16'h8000, 16'h1234, 16'h00FF, 16'hFFFF};
    vb = '{16'h0001, 16'h0001, 16'h8000, 16'h0101, 16'h0001, 16'h0001};
    ve = '{17'h000C0, 17'h0FFC0, 17'h10000, 17'h01335, 17'h00100, 17'h10000};
    vr = '{1, 2, 3, 0, 1, 2};
    nv = 4;
`ifdef RAP_EXACT_MODE_EN
    nv = 6;
`endif
    for (int v = 0; v < nv; v++) begin
`ifdef RAP_EXACT_MODE_EN
      bus_if.req_exact = (v >= 4) ? (4'b0001 << vr[v]) : 4'b0000;
`endif
      do_op(vr[v], va[v], vb[v]);
      checks++; if (bus_if.rsp_valid[vr[v]] !== 1'b1) begin errors++; $display("[TB] FAIL carry_valid_%0d: got %b expected 1", v, bus_if.rsp_valid[vr[v]]); end
      checks++; if (slot(vr[v]) !== ve[v]) begin errors++; $display("[TB] FAIL carry_sum_%0d: got %h expected %h", v, slot(vr[v]), ve[v]); end
    end
`ifdef RAP_EXACT_MODE_EN
    bus_if.req_exact = '0;
`endif
  endtask

  task automatic test_round_robin();
    logic [16:0] exp_sum [4];
    logic [3:0]  exp_vec;
    int          s;
    exp_sum = '{17'h00111, 17'h00122, 17'h00133, 17'h00144};
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 16'h0011 * 16'(i + 1), 16'h0100);
    bus_if.req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_vec = 4'b0001 << (c % 4);
      checks++; if (bus_if.req_ready !== exp_vec) begin errors++; $display("[TB] FAIL rr_grant_c%0d: got %b expected %b", c, bus_if.req_ready, exp_vec); end
      if (c >= 1) begin
        checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL rr_busy_c%0d: got %b expected 1", c, bus_if.busy); end
      end
      if (c >= 2) begin
        s = (c - 2) % 4;
        exp_vec = 4'b0001 << s;
        checks++; if (bus_if.rsp_valid !== exp_vec) begin errors++; $display("[TB] FAIL rr_rsp_valid_c%0d: got %b expected %b", c, bus_if.rsp_valid, exp_vec); end
        checks++; if (slot(s) !== exp_sum[s]) begin errors++; $display("[TB] FAIL rr_sum_c%0d: got %h expected %h", c, slot(s), exp_sum[s]); end
      end
      @(posedge clk);
      #1;
    end
    bus_if.req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_busy_drained: got %b expected 0", bus_if.busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus_if.rsp_ready = 4'b1011;
    do_op(2, 16'h0005, 16'h0003);
    checks++; if (bus_if.rsp_valid !== 4'b0100) begin errors++; $display("[TB] FAIL bp_pending: got %b expected 0100", bus_if.rsp_valid); end
    checks++; if (slot(2) !== 17'h00008) begin errors++; $display("[TB] FAIL bp_first_sum: got %h expected 00008", slot(2)); end
    @(posedge clk);
    #1;
    set_req(0, 16'h0001, 16'h0001);
    set_req(1, 16'h0003, 16'h0000);
    set_req(2, 16'h0020, 16'h0002);
    bus_if.req_valid = 4'b0111;
    @(negedge clk);
    checks++; if (bus_if.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL bp_wrap_grant: got %b expected 0001", bus_if.req_ready); end
    @(posedge clk);
    #1;
    bus_if.req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_second_grant: got %b expected 0010", bus_if.req_ready); end
    @(posedge clk);
    #1;
    bus_if.req_valid[1] = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_blocked: got %b expected 0000", bus_if.req_ready); end
    checks++; if (bus_if.rsp_valid !== 4'b0101) begin errors++; $display("[TB] FAIL bp_rsp_mix: got %b expected 0101", bus_if.rsp_valid); end
    checks++; if (slot(0) !== 17'h00002) begin errors++; $display("[TB] FAIL bp_sum0: got %h expected 00002", slot(0)); end
    bus_if.rsp_ready[2] = 1'b1;
    #1;
    checks++; if (bus_if.req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL bp_release_grant: got %b expected 0100", bus_if.req_ready); end
    checks++; if (slot(2) !== 17'h00008) begin errors++; $display("[TB] FAIL bp_hold_sum: got %h expected 00008", slot(2)); end
    @(posedge clk);
    #1;
    bus_if.req_valid[2] = 1'b0;
    bus_if.rsp_ready[2] = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.rsp_valid !== 4'b0010) begin errors++; $display("[TB] FAIL bp_after_accept: got %b expected 0010", bus_if.rsp_valid); end
    checks++; if (slot(1) !== 17'h00003) begin errors++; $display("[TB] FAIL bp_sum1: got %h expected 00003", slot(1)); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus_if.rsp_valid !== 4'b0100) begin errors++; $display("[TB] FAIL bp_new_valid: got %b expected 0100", bus_if.rsp_valid); end
    checks++; if (slot(2) !== 17'h00022) begin errors++; $display("[TB] FAIL bp_new_sum: got %h expected 00022", slot(2)); end
  endtask

  task automatic test_single_lane();
    do_reset();
    bus_if.rsp_ready = 4'b0000;
    do_op(0, 16'h0001, 16'h0001);
    checks++; if (slot(0) !== 17'h00002) begin errors++; $display("[TB] FAIL lane_first_sum: got %h expected 00002", slot(0)); end
    @(posedge clk);
    #1;
    set_req(0, 16'h0004, 16'h0004);
    bus_if.req_valid[0] = 1'b1;
    bus_if.rsp_ready[0] = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL lane_drain_grant: got %b expected 0001", bus_if.req_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus_if.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL lane_inflight_block: got %b expected 0000", bus_if.req_ready); end
    checks++; if (bus_if.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL lane_drained: got %b expected 0000", bus_if.rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus_if.rsp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL lane_valid: got %b expected 0001", bus_if.rsp_valid); end
    checks++; if (slot(0) !== 17'h00008) begin errors++; $display("[TB] FAIL lane_sum: got %h expected 00008", slot(0)); end
    checks++; if (bus_if.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL lane_regrant: got %b expected 0001", bus_if.req_ready); end
    set_req(0, 16'h00F0, 16'h000F);
    @(posedge clk);
    #1;
    bus_if.req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL lane_second_drain: got %b expected 0000", bus_if.rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (slot(0) !== 17'h000FF) begin errors++; $display("[TB] FAIL lane_second_sum: got %h expected 000FF", slot(0)); end
    bus_if.rsp_ready = 4'b1111;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_if.rsp_ready = 4'b0000;
    do_op(1, 16'h0100, 16'h0001);
    do_op(3, 16'h0002, 16'h0002);
    @(posedge clk);
    #1;
    set_req(0, 16'h0007, 16'h0001);
    bus_if.req_valid[0] = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.req_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL mid_grant: got %b expected 1", bus_if.req_ready[0]); end
    @(posedge clk);
    #1;
    bus_if.req_valid[0] = 1'b0;
    #1;
    checks++; if (bus_if.rsp_valid !== 4'b1010) begin errors++; $display("[TB] FAIL mid_pending: got %b expected 1010", bus_if.rsp_valid); end
    checks++; if (slot(3) !== 17'h00004) begin errors++; $display("[TB] FAIL mid_sum3: got %h expected 00004", slot(3)); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL mid_async_valid: got %b expected 0000", bus_if.rsp_valid); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_busy: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.rsp_sum !== 68'h0) begin errors++; $display("[TB] FAIL mid_async_sum: got %h expected 0", bus_if.rsp_sum); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus_if.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL mid_spurious_c%0d: got %b expected 0000", c, bus_if.rsp_valid); end
    end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy_after: got %b expected 0", bus_if.busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_long_carry();
    test_round_robin();
    test_backpressure();
    test_single_lane();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
